// File: rtl/rv32_mem_port_arbiter_pkg.sv
// Shared types for the two-requester memory port arbiter: memory access/exception
// types reused by the memory map, plus arbiter state and request-register layout.
package rv32_mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'd0,
    MEM_HALF = 2'd1,
    MEM_WORD = 2'd2
  } mem_access_t;

  typedef struct packed {
    logic load_misaligned;
    logic load_fault;
    logic store_misaligned;
    logic store_fault;
  } mem_exception_mask_t;

  typedef logic [0:0] arb_state_t;
  localparam arb_state_t S_IDLE = 1'b0;
  localparam arb_state_t S_WAIT = 1'b1;

  localparam int MAX_ARB_LATENCY = 4;
  localparam int ARB_CNT_W       = $clog2(MAX_ARB_LATENCY + 1);

  // Layout of the latched request: 32 + 32 + 2 + 1 + 1 bits.
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wr_data;
    mem_access_t access;
    logic        wr_ena;
    logic        owner;
  } arb_req_t;

endpackage

// File: rtl/rv32_mem_port_arbiter_if.sv
// Requester-side bundle of the memory port arbiter: per-requester request inputs
// and the grant/completion outputs routed back to them.
interface rv32_mem_port_arbiter_if;
  import rv32_mem_port_arbiter_pkg::*;

  logic [1:0]          req;
  logic [31:0]         addr0;
  logic [31:0]         addr1;
  logic [31:0]         wr_data0;
  logic [31:0]         wr_data1;
  logic [1:0]          wr_ena;
  mem_access_t         access0;
  mem_access_t         access1;
  logic [1:0]          gnt;
  logic [1:0]          rd_valid;
  logic [31:0]         rd_data;
  mem_exception_mask_t exception0;
  mem_exception_mask_t exception1;

  modport master (
    output req, addr0, addr1, wr_data0, wr_data1, wr_ena, access0, access1,
    input  gnt, rd_valid, rd_data, exception0, exception1
  );

  modport slave (
    input  req, addr0, addr1, wr_data0, wr_data1, wr_ena, access0, access1,
    output gnt, rd_valid, rd_data, exception0, exception1
  );
endinterface

// File: rtl/register.sv
// Generic N-bit register with load enable and synchronous active-high reset.
module register #(
  parameter int N = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ena,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);
  always_ff @(posedge clk) begin
    if (rst)      q <= '0;
    else if (ena) q <= d;
  end
endmodule

// File: rtl/rv32_mem_port_arbiter.sv
// Shares the single memory port between the multicycle core (requester 0) and a
// DMA/debug loader (requester 1); one access in flight, fixed LATENCY to completion.
module rv32_mem_port_arbiter
  import rv32_mem_port_arbiter_pkg::*;
#(
  parameter int LATENCY     = 1,
  parameter bit ROUND_ROBIN = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  rv32_mem_port_arbiter_if.slave bus,
  output logic                 busy,
  output logic [31:0]          mem_addr,
  output logic [31:0]          mem_wr_data,
  output logic                 mem_wr_ena,
  output mem_access_t          mem_access,
  input  logic [31:0]          mem_rd_data,
  input  mem_exception_mask_t  mem_exception
);

  arb_state_t           state;
  logic [ARB_CNT_W-1:0] cnt;
  logic                 last_winner;
  logic                 winner;
  logic                 grant;
  logic                 done;
  arb_req_t             cur_req;
  arb_req_t             held_req;
  logic                 held_wr_ena_unused;

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path infers a latch.
    winner = 1'b0;
    case (bus.req)
      2'b10:   winner = 1'b1;
      2'b11:   winner = ROUND_ROBIN ? ~last_winner : 1'b0;
      default: winner = 1'b0;
    endcase
  end

  assign grant = (state == S_IDLE) && (bus.req != 2'b00) && !rst;
  assign done  = (state == S_WAIT) && (cnt == ARB_CNT_W'(1));

  assign cur_req = '{
    addr:    winner ? bus.addr1    : bus.addr0,
    wr_data: winner ? bus.wr_data1 : bus.wr_data0,
    access:  winner ? bus.access1  : bus.access0,
    wr_ena:  bus.wr_ena[winner],
    owner:   winner
  };

  register #(.N($bits(arb_req_t))) u_req_reg (
    .clk (clk),
    .rst (rst),
    .ena (grant),
    .d   (cur_req),
    .q   (held_req)
  );

  // The latched store flag is only carried for the downstream trace; the write
  // itself commits in the grant cycle.
  assign held_wr_ena_unused = held_req.wr_ena;

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      last_winner <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (grant) begin
            state       <= S_WAIT;
            cnt         <= ARB_CNT_W'(LATENCY);
            last_winner <= winner;
          end
        end
        S_WAIT: begin
          cnt <= cnt - 1'b1;
          if (cnt == ARB_CNT_W'(1)) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    mem_addr    = '0;
    mem_wr_data = '0;
    mem_wr_ena  = 1'b0;
    mem_access  = MEM_BYTE;
    if (grant) begin
      mem_addr    = cur_req.addr;
      mem_wr_data = cur_req.wr_data;
      mem_wr_ena  = cur_req.wr_ena;
      mem_access  = cur_req.access;
    end else if (state == S_WAIT) begin
      mem_addr    = held_req.addr;
      mem_wr_data = held_req.wr_data;
      mem_access  = held_req.access;
    end
  end

  assign busy           = (state != S_IDLE);
  assign bus.gnt        = grant ? (winner ? 2'b10 : 2'b01) : 2'b00;
  assign bus.rd_valid   = done ? (held_req.owner ? 2'b10 : 2'b01) : 2'b00;
  assign bus.rd_data    = done ? mem_rd_data : '0;
  assign bus.exception0 = (done && !held_req.owner) ? mem_exception : '0;
  assign bus.exception1 = (done &&  held_req.owner) ? mem_exception : '0;

endmodule

// File: tb/tb_rv32_mem_port_arbiter.sv
// Bench for rv32_mem_port_arbiter: three configurations share one stimulus set;
// completions are scored against a queue of expected results.
module tb_rv32_mem_port_arbiter;
  import rv32_mem_port_arbiter_pkg::*;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [1:0]          req = 2'b00;
  logic [31:0]         addr0 = '0, addr1 = '0, wr_data0 = '0, wr_data1 = '0;
  logic [1:0]          wr_ena = 2'b00;
  mem_access_t         access0 = MEM_WORD, access1 = MEM_WORD;
  logic [31:0]         mem_rd_data = '0;
  mem_exception_mask_t mem_exception = '0;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int act    = 0;
  bit mon_en = 1'b0;

  typedef struct packed {
    logic [1:0]          gnt;
    logic [1:0]          rd_valid;
    logic [31:0]         rd_data;
    mem_exception_mask_t e0;
    mem_exception_mask_t e1;
    logic                busy;
    logic [31:0]         mem_addr;
    logic [31:0]         mem_wr_data;
    logic                mem_wr_ena;
    mem_access_t         mem_access;
  } obs_t;

  typedef struct {
    logic [1:0]  owner;
    logic [31:0] data;
    logic [3:0]  e0;
    logic [3:0]  e1;
    int          due;
  } exp_t;

  obs_t obs [3];
  exp_t exp_q [$];
  exp_t exp_item;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Instance 0: LATENCY=1 round-robin; 1: LATENCY=3 fixed; 2: LATENCY=3 round-robin.
  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 1 : 3;
    localparam bit RR  = (g != 1);
    rv32_mem_port_arbiter_if bus ();
    logic                busy;
    logic [31:0]         mem_addr, mem_wr_data;
    logic                mem_wr_ena;
    mem_access_t         mem_access;

    assign bus.req      = req;
    assign bus.addr0    = addr0;
    assign bus.addr1    = addr1;
    assign bus.wr_data0 = wr_data0;
    assign bus.wr_data1 = wr_data1;
    assign bus.wr_ena   = wr_ena;
    assign bus.access0  = access0;
    assign bus.access1  = access1;

    rv32_mem_port_arbiter #(.LATENCY(LAT), .ROUND_ROBIN(RR)) dut (
      .clk           (clk),
      .rst           (rst),
      .bus           (bus.slave),
      .busy          (busy),
      .mem_addr      (mem_addr),
      .mem_wr_data   (mem_wr_data),
      .mem_wr_ena    (mem_wr_ena),
      .mem_access    (mem_access),
      .mem_rd_data   (mem_rd_data),
      .mem_exception (mem_exception)
    );

    assign obs[g] = {bus.gnt, bus.rd_valid, bus.rd_data, bus.exception0, bus.exception1,
                     busy, mem_addr, mem_wr_data, mem_wr_ena, mem_access};
  end

  // Completion scoreboard for the instance under test.
  always @(negedge clk) begin
    if (mon_en && obs[act].rd_valid !== 2'b00) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_completion dut%0d cycle %0d: got rd_valid=%b, required none",
                 act, cyc, obs[act].rd_valid);
      end else begin
        exp_item = exp_q.pop_front();
        if (obs[act].rd_valid !== exp_item.owner || obs[act].rd_data !== exp_item.data ||
            obs[act].e0 !== exp_item.e0 || obs[act].e1 !== exp_item.e1 || cyc != exp_item.due) begin
          errors++;
          $display("FAIL completion dut%0d: got rd_valid=%b data=%h e0=%h e1=%h cycle=%0d, required rd_valid=%b data=%h e0=%h e1=%h cycle=%0d",
                   act, obs[act].rd_valid, obs[act].rd_data, obs[act].e0, obs[act].e1, cyc,
                   exp_item.owner, exp_item.data, exp_item.e0, exp_item.e1, exp_item.due);
        end
      end
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic do_reset(input int which);
    mon_en = 1'b0;
    rst = 1'b1; req = 2'b00; wr_ena = 2'b00;
    mem_exception = '0; mem_rd_data = '0;
    exp_q.delete();
    act = which;
    nxt(); nxt();
    rst = 1'b0; mon_en = 1'b1;
  endtask

  task automatic test_drained(input string name);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drained: got %0d pending completions, required 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    mon_en = 1'b0; rst = 1'b1; req = 2'b11;
    addr0 = 32'h1111_1111; addr1 = 32'h2222_2222; wr_ena = 2'b11;
    nxt(); nxt(); smp();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (obs[i] !== '0) begin
        errors++;
        $display("FAIL reset_with_req dut%0d: got outputs=%h, required all zero", i, obs[i]);
      end
    end
    nxt(); req = 2'b00; wr_ena = 2'b00; smp();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (obs[i] !== '0) begin
        errors++;
        $display("FAIL reset_idle dut%0d: got outputs=%h, required all zero", i, obs[i]);
      end
    end
  endtask

  task automatic test_single_load();
    do_reset(0);
    req = 2'b01; addr0 = 32'h1000_0010; addr1 = 32'h2000_0000; access0 = MEM_WORD;
    mem_rd_data = 32'hDEAD_BEEF;
    exp_q.push_back('{2'b01, 32'hDEAD_BEEF, 4'h0, 4'h0, cyc + 1});
    smp();
    checks++;
    if (obs[0].gnt !== 2'b01 || obs[0].mem_addr !== 32'h1000_0010 || obs[0].mem_wr_ena !== 1'b0 ||
        obs[0].busy !== 1'b0 || obs[0].mem_access !== MEM_WORD) begin
      errors++;
      $display("FAIL load_grant: got gnt=%b addr=%h we=%b busy=%b acc=%0d, required gnt=01 addr=10000010 we=0 busy=0 acc=2",
               obs[0].gnt, obs[0].mem_addr, obs[0].mem_wr_ena, obs[0].busy, obs[0].mem_access);
    end
    nxt(); req = 2'b00; smp();
    checks++;
    if (obs[0].gnt !== 2'b00 || obs[0].busy !== 1'b1 || obs[0].mem_addr !== 32'h1000_0010) begin
      errors++;
      $display("FAIL load_wait: got gnt=%b busy=%b addr=%h, required gnt=00 busy=1 addr=10000010",
               obs[0].gnt, obs[0].busy, obs[0].mem_addr);
    end
    nxt(); smp();
    checks++;
    if (obs[0].busy !== 1'b0 || obs[0].rd_valid !== 2'b00 || obs[0].mem_addr !== 32'h0) begin
      errors++;
      $display("FAIL load_idle: got busy=%b rd_valid=%b addr=%h, required busy=0 rd_valid=00 addr=0",
               obs[0].busy, obs[0].rd_valid, obs[0].mem_addr);
    end
    test_drained("load");
  endtask

  task automatic test_store();
    do_reset(0);
    req = 2'b10; wr_ena = 2'b10;
    addr0 = 32'h1000_0030; wr_data0 = 32'hFFFF_0000; access0 = MEM_WORD;
    addr1 = 32'h1000_0020; wr_data1 = 32'h1234_5678; access1 = MEM_HALF;
    mem_rd_data = 32'h0000_5A5A;
    exp_q.push_back('{2'b10, 32'h0000_5A5A, 4'h0, 4'h0, cyc + 1});
    smp();
    checks++;
    if (obs[0].gnt !== 2'b10 || obs[0].mem_wr_ena !== 1'b1 || obs[0].mem_wr_data !== 32'h1234_5678 ||
        obs[0].mem_addr !== 32'h1000_0020 || obs[0].mem_access !== MEM_HALF) begin
      errors++;
      $display("FAIL store_grant: got gnt=%b we=%b wdata=%h addr=%h acc=%0d, required gnt=10 we=1 wdata=12345678 addr=10000020 acc=1",
               obs[0].gnt, obs[0].mem_wr_ena, obs[0].mem_wr_data, obs[0].mem_addr, obs[0].mem_access);
    end
    nxt(); req = 2'b00; wr_ena = 2'b00; smp();
    checks++;
    if (obs[0].mem_wr_ena !== 1'b0 || obs[0].mem_addr !== 32'h1000_0020 ||
        obs[0].mem_wr_data !== 32'h1234_5678) begin
      errors++;
      $display("FAIL store_wait: got we=%b addr=%h wdata=%h, required we=0 addr=10000020 wdata=12345678",
               obs[0].mem_wr_ena, obs[0].mem_addr, obs[0].mem_wr_data);
    end
    nxt(); smp();
    checks++;
    if (obs[0].busy !== 1'b0 || obs[0].mem_wr_ena !== 1'b0 || obs[0].mem_wr_data !== 32'h0) begin
      errors++;
      $display("FAIL store_idle: got busy=%b we=%b wdata=%h, required busy=0 we=0 wdata=0",
               obs[0].busy, obs[0].mem_wr_ena, obs[0].mem_wr_data);
    end
    test_drained("store");
  endtask

  task automatic test_contention_rr();
    logic [1:0] eg;
    do_reset(0);
    req = 2'b11; wr_ena = 2'b00;
    addr0 = 32'h0000_A000; addr1 = 32'h0000_B000;
    for (int c = 0; c < 8; c++) begin
      mem_rd_data = 32'hA000_0000 + c;
      eg = 2'b00;
      if (c % 2 == 0) begin
        eg = (c % 4 == 0) ? 2'b01 : 2'b10;
        exp_q.push_back('{eg, 32'hA000_0000 + c + 1, 4'h0, 4'h0, cyc + 1});
      end
      smp();
      checks++;
      if (obs[0].gnt !== eg || (eg != 2'b00 && obs[0].mem_addr !== (eg[1] ? addr1 : addr0))) begin
        errors++;
        $display("FAIL rr_grant cycle %0d: got gnt=%b addr=%h, required gnt=%b", c,
                 obs[0].gnt, obs[0].mem_addr, eg);
      end
      nxt();
    end
    req = 2'b00; smp(); nxt(); smp();
    test_drained("rr");
  endtask

  task automatic test_fixed_priority();
    logic [1:0] eg;
    do_reset(1);
    addr0 = 32'h0000_C000; addr1 = 32'h0000_D000; wr_ena = 2'b00;
    for (int c = 0; c < 12; c++) begin
      req = (c < 10) ? 2'b11 : 2'b00;
      mem_rd_data = 32'hB000_0000 + c;
      eg = (c % 4 == 0 && c < 10) ? 2'b01 : 2'b00;
      if (eg != 2'b00) exp_q.push_back('{2'b01, 32'hB000_0000 + c + 3, 4'h0, 4'h0, cyc + 3});
      smp();
      checks++;
      if (obs[1].gnt !== eg || (eg != 2'b00 && obs[1].mem_addr !== 32'h0000_C000)) begin
        errors++;
        $display("FAIL fixed_grant cycle %0d: got gnt=%b addr=%h, required gnt=%b", c,
                 obs[1].gnt, obs[1].mem_addr, eg);
      end
      nxt();
    end
    smp();
    test_drained("fixed");
  endtask

  task automatic test_exception();
    do_reset(0);
    req = 2'b10; wr_ena = 2'b00; addr1 = 32'h1000_0044; addr0 = 32'h1000_0040;
    mem_exception = 4'b1111; mem_rd_data = 32'h0BAD_0001;
    exp_q.push_back('{2'b10, 32'h0BAD_0001, 4'h0, 4'b0101, cyc + 1});
    smp();
    checks++;
    if (obs[0].e0 !== 4'h0 || obs[0].e1 !== 4'h0 || obs[0].rd_data !== 32'h0) begin
      errors++;
      $display("FAIL exc_grant_quiet: got e0=%h e1=%h rd_data=%h, required 0 0 0",
               obs[0].e0, obs[0].e1, obs[0].rd_data);
    end
    nxt(); req = 2'b00; mem_exception = 4'b0101; smp();
    nxt(); req = 2'b01; mem_exception = 4'b1111; mem_rd_data = 32'h0BAD_0002;
    exp_q.push_back('{2'b01, 32'h0BAD_0002, 4'b1010, 4'h0, cyc + 1});
    smp();
    nxt(); req = 2'b00; mem_exception = 4'b1010; smp();
    nxt(); smp();
    checks++;
    if (obs[0].e0 !== 4'h0 || obs[0].e1 !== 4'h0) begin
      errors++;
      $display("FAIL exc_idle_quiet: got e0=%h e1=%h, required 0 0", obs[0].e0, obs[0].e1);
    end
    test_drained("exception");
  endtask

  task automatic test_reset_mid_access();
    logic [1:0] eg;
    do_reset(2);
    req = 2'b11; addr0 = 32'h0000_E000; addr1 = 32'h0000_F000; wr_ena = 2'b00;
    smp();
    checks++;
    if (obs[2].gnt !== 2'b01) begin
      errors++;
      $display("FAIL mid_first_grant: got gnt=%b, required 01", obs[2].gnt);
    end
    nxt(); req = 2'b00; rst = 1'b1; smp();
    nxt(); smp();
    checks++;
    if (obs[2] !== '0) begin
      errors++;
      $display("FAIL mid_reset_outputs: got outputs=%h, required all zero", obs[2]);
    end
    nxt(); rst = 1'b0; smp();
    checks++;
    if (obs[2] !== '0) begin
      errors++;
      $display("FAIL mid_after_reset: got outputs=%h, required all zero", obs[2]);
    end
    nxt(); smp();
    nxt();
    for (int c = 0; c < 9; c++) begin
      req = (c < 8) ? 2'b11 : 2'b00;
      mem_rd_data = 32'hD000_0000 + c;
      eg = (c == 0) ? 2'b01 : (c == 4) ? 2'b10 : 2'b00;
      if (eg != 2'b00) exp_q.push_back('{eg, 32'hD000_0000 + c + 3, 4'h0, 4'h0, cyc + 3});
      smp();
      checks++;
      if (obs[2].gnt !== eg) begin
        errors++;
        $display("FAIL mid_regrant cycle %0d: got gnt=%b, required %b", c, obs[2].gnt, eg);
      end
      nxt();
    end
    smp();
    test_drained("reset_mid");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single_load();
    test_store();
    test_contention_rr();
    test_fixed_priority();
    test_exception();
    test_reset_mid_access();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
